// File: rtl/frame_rx_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : frame_rx_ctrl_pkg
//  Purpose  : Shared constants and types for the serial frame receiver:
//             the sync byte, the receiver state enumeration, the error
//             code encodings and a small bit-shift helper.
//  Revision : 1.0 - initial release
// ============================================================================
package frame_rx_ctrl_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CHECK   = 2'd3
  } state_t;

  localparam logic [1:0] ERR_TIMEOUT  = 2'd0;
  localparam logic [1:0] ERR_CHECKSUM = 2'd1;
  localparam logic [1:0] ERR_LENGTH   = 2'd2;
  localparam logic [1:0] ERR_OVERFLOW = 2'd3;

  // Append one serial bit (MSB first) to the 7 most recent bits.
  function automatic logic [7:0] shift_in(input logic [6:0] hist, input logic bit_in);
    return {hist, bit_in};
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_rx_ctrl_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : frame_fifo
//  Purpose  : Synchronous byte FIFO holding received payload bytes.
//             A push into a full FIFO is accepted only when a pop happens in
//             the same cycle; otherwise it is ignored.
//  Ports    : clk, rst_n      - clock, asynchronous active-low reset
//             push, push_data - write strobe and byte
//             pop             - read strobe (ignored when empty)
//             pop_data        - head byte (0 after reset)
//             full, empty     - occupancy flags
//  Revision : 1.0 - initial release
// ============================================================================
module frame_fifo #(
  parameter int DEPTH = 4  // power of 2, at least 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_PTR_ONE = (AW + 1)'(1);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic [7:0]  mem_d [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + C_PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + C_PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/frame_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : frame_rx_ctrl
//  Purpose  : Serial frame receiver. Hunts for the sync byte on a bit
//             stream, then receives LEN, LEN payload bytes and an XOR
//             checksum. Payload bytes are buffered in a FIFO; the frame
//             outcome is reported by a done or error pulse.
//  Ports    : clk, rst_n         - clock, asynchronous active-low reset
//             shift_enable       - serial_in valid this cycle
//             serial_in          - serial data, MSB first
//             payload_data       - FIFO head byte
//             payload_valid      - FIFO not empty
//             payload_ready      - consumer pops when valid & ready
//             frame_done         - pulse: frame checksum matched
//             frame_err          - pulse: frame aborted
//             err_code           - abort reason, held between pulses
//             busy               - receiver is inside a frame
//  Revision : 1.0 - initial release
// ============================================================================
module frame_rx_ctrl
  import frame_rx_ctrl_pkg::*;
#(
  parameter int MAX_LEN    = 16,
  parameter int TIMEOUT    = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       shift_enable,
  input  logic       serial_in,
  output logic [7:0] payload_data,
  output logic       payload_valid,
  input  logic       payload_ready,
  output logic       frame_done,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int         IW          = $clog2(TIMEOUT + 1);
  localparam logic [7:0] C_MAX_LEN   = 8'(MAX_LEN);
  localparam logic [IW-1:0] C_IDLE_LAST = IW'(TIMEOUT - 1);
  localparam logic [IW-1:0] C_IDLE_ONE  = IW'(1);

  state_t        state_q, state_d;
  logic [6:0]    acc_q, acc_d;          // sync window in HUNT, byte accumulator elsewhere
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    chk_q, chk_d;
  logic [7:0]    rem_q, rem_d;          // payload bytes still expected
  logic [IW-1:0] idle_q, idle_d;        // clocks since the last completed byte
  logic          push_q, push_d;
  logic [7:0]    push_data_q, push_data_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [1:0]    err_code_q, err_code_d;

  logic [7:0]    shift_byte;
  logic          byte_done;
  logic          to_hunt;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic          overflow;

  assign shift_byte = shift_in(acc_q, serial_in);
  assign byte_done  = (state_q != ST_HUNT) && shift_enable && (bit_cnt_q == 3'd7);
  assign fifo_pop   = payload_valid & payload_ready;
  // A byte pushed into a full FIFO survives only if a pop frees a slot now.
  assign overflow   = push_q & fifo_full & ~fifo_pop;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    bit_cnt_d   = bit_cnt_q;
    chk_d       = chk_q;
    rem_d       = rem_q;
    idle_d      = idle_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    to_hunt     = 1'b0;

    if (state_q == ST_HUNT) begin
      if (shift_enable) begin
        acc_d = shift_byte[6:0];
        if (shift_byte == SYNC_BYTE) begin
          state_d   = ST_LEN;
          acc_d     = '0;
          bit_cnt_d = '0;
        end
      end
    end else begin
      if (shift_enable) begin
        acc_d     = shift_byte[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;   // wraps to 0 after the 8th bit
      end
      idle_d = byte_done ? '0 : (idle_q + C_IDLE_ONE);

      if (overflow) begin
        // The delayed push of the previous byte found no room.
        err_d      = 1'b1;
        err_code_d = ERR_OVERFLOW;
        to_hunt    = 1'b1;
      end else if (byte_done) begin
        // A completed byte takes priority over an expiring idle count.
        case (state_q)
          ST_LEN: begin
            if (shift_byte > C_MAX_LEN) begin
              err_d      = 1'b1;
              err_code_d = ERR_LENGTH;
              to_hunt    = 1'b1;
            end else begin
              chk_d   = shift_byte;
              rem_d   = shift_byte;
              state_d = (shift_byte == 8'd0) ? ST_CHECK : ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            push_d      = 1'b1;
            push_data_d = shift_byte;
            chk_d       = chk_q ^ shift_byte;
            rem_d       = rem_q - 8'd1;
            if (rem_q == 8'd1) begin
              state_d = ST_CHECK;
            end
          end
          ST_CHECK: begin
            if (shift_byte == chk_q) begin
              done_d = 1'b1;
            end else begin
              err_d      = 1'b1;
              err_code_d = ERR_CHECKSUM;
            end
            to_hunt = 1'b1;
          end
          default: begin
            to_hunt = 1'b1;
          end
        endcase
      end else if (idle_q == C_IDLE_LAST) begin
        err_d      = 1'b1;
        err_code_d = ERR_TIMEOUT;
        to_hunt    = 1'b1;
      end
    end

    if (to_hunt) begin
      state_d   = ST_HUNT;
      acc_d     = '0;
      bit_cnt_d = '0;
      chk_d     = '0;
      rem_d     = '0;
      idle_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HUNT;
      acc_q       <= '0;
      bit_cnt_q   <= '0;
      chk_q       <= '0;
      rem_q       <= '0;
      idle_q      <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      bit_cnt_q   <= bit_cnt_d;
      chk_q       <= chk_d;
      rem_q       <= rem_d;
      idle_q      <= idle_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  frame_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_q & ~overflow),
    .push_data (push_data_q),
    .pop       (fifo_pop),
    .pop_data  (payload_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign payload_valid = ~fifo_empty;
  assign frame_done    = done_q;
  assign frame_err     = err_q;
  assign err_code      = err_code_q;
  assign busy          = (state_q != ST_HUNT);

endmodule
`default_nettype wire

// File: tb/tb_frame_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frame_rx_ctrl
//  Purpose  : Self-checking bench for frame_rx_ctrl. Directed scenarios plus
//             randomized bit streams compared against a frame-level parser.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_frame_rx_ctrl;

  localparam int MAX_LEN    = 16;
  localparam int TIMEOUT    = 64;
  localparam int FIFO_DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       shift_enable;
  logic       serial_in;
  logic       payload_ready;
  logic [7:0] payload_data;
  logic       payload_valid;
  logic       frame_done;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  int checks   = 0;
  int errors   = 0;
  int both_cnt = 0;
  bit rnd_ready = 1'b0;

  bit         stim[$];
  logic [7:0] got_bytes[$];
  logic [7:0] exp_bytes[$];
  int         got_ev[$];     // -1 = frame_done, 0..3 = frame_err code
  int         exp_ev[$];

  frame_rx_ctrl #(
    .MAX_LEN    (MAX_LEN),
    .TIMEOUT    (TIMEOUT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .shift_enable  (shift_enable),
    .serial_in     (serial_in),
    .payload_data  (payload_data),
    .payload_valid (payload_valid),
    .payload_ready (payload_ready),
    .frame_done    (frame_done),
    .frame_err     (frame_err),
    .err_code      (err_code),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Observer: sampled mid-cycle, records pops and frame outcomes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (payload_valid && payload_ready) got_bytes.push_back(payload_data);
      if (frame_done) got_ev.push_back(-1);
      if (frame_err)  got_ev.push_back(int'(err_code));
      if (frame_done && frame_err) both_cnt++;
    end
  end

  function automatic string bytes_str(input logic [7:0] q[$]);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
    return s;
  endfunction

  function automatic string ev_str(input int q[$]);
    string s = "";
    foreach (q[i]) s = {s, (q[i] < 0) ? "D " : $sformatf("E%0d ", q[i])};
    return s;
  endfunction

  function automatic logic [7:0] get_byte(input int p);
    logic [7:0] v = '0;
    for (int i = 0; i < 8; i++) v = {v[6:0], stim[p + i]};
    return v;
  endfunction

  // Frame-level reference: scan the bit stream for sync, parse LEN/payload/CHK.
  // A frame left incomplete at the end of the stream ends in a timeout.
  task automatic model_run();
    int n = stim.size();
    int p = 0;
    bit pend = 0;
    bit found;
    logic [7:0] w, len, sum, b;
    exp_bytes.delete();
    exp_ev.delete();
    while (p < n && !pend) begin
      w = '0;
      found = 0;
      while (p < n && !found) begin
        w = {w[6:0], stim[p]};
        p++;
        found = (w == 8'hA5);
      end
      if (!found) break;
      if (p + 8 > n) begin pend = 1; break; end
      len = get_byte(p); p += 8;
      if (int'(len) > MAX_LEN) begin exp_ev.push_back(2); continue; end
      sum = len;
      for (int k = 0; k < int'(len); k++) begin
        if (p + 8 > n) begin pend = 1; break; end
        b = get_byte(p); p += 8;
        exp_bytes.push_back(b);
        sum ^= b;
      end
      if (pend) break;
      if (p + 8 > n) begin pend = 1; break; end
      b = get_byte(p); p += 8;
      exp_ev.push_back((b == sum) ? -1 : 1);
    end
    if (pend) exp_ev.push_back(0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input bit b, input int max_gap);
    int g;
    g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
    repeat (g) begin
      shift_enable = 1'b0;
      serial_in    = 1'($urandom_range(0, 1));
      if (rnd_ready) payload_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    shift_enable = 1'b1;
    serial_in    = b;
    if (rnd_ready) payload_ready = ($urandom_range(0, 3) != 0);
    tick();
    shift_enable = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) stim.push_back(v[i]);
  endtask

  task automatic send_stim(input int max_gap);
    foreach (stim[i]) drive_bit(stim[i], max_gap);
    stim.delete();
  endtask

  task automatic idle(input int n);
    shift_enable = 1'b0;
    repeat (n) tick();
  endtask

  task automatic clear_obs();
    got_bytes.delete();
    got_ev.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; shift_enable = 1'b0; serial_in = 1'b0; payload_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (payload_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", payload_valid); end
    checks++; if (payload_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h expected 00", payload_data); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", frame_done); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", frame_err); end
    checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL reset_code: got %0d expected 0", err_code); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_good_frame();
    clear_obs(); rnd_ready = 0; payload_ready = 1'b1;
    push_byte(8'hA5); push_byte(8'h03); push_byte(8'h11);
    push_byte(8'h22); push_byte(8'h33); push_byte(8'h03);
    send_stim(0);
    idle(10);
    checks++; if (bytes_str(got_bytes) != "11 22 33 ") begin errors++; $display("FAIL good_bytes: got '%s' expected '11 22 33 '", bytes_str(got_bytes)); end
    checks++; if (ev_str(got_ev) != "D ") begin errors++; $display("FAIL good_events: got '%s' expected 'D '", ev_str(got_ev)); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL good_busy: got %b expected 0", busy); end
  endtask

  task automatic test_bad_checksum();
    bit seen = 0;
    clear_obs(); payload_ready = 1'b1;
    push_byte(8'hA5); push_byte(8'h03); push_byte(8'h11);
    push_byte(8'h22); push_byte(8'h33); push_byte(8'h04);
    send_stim(0);
    for (int c = 0; c < 4 && !seen; c++) begin
      if (frame_err) seen = 1;
      else tick();
    end
    checks++; if (!seen) begin errors++; $display("FAIL badchk_pulse: got no frame_err expected frame_err within 4 cycles"); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL badchk_busy: got %b expected 0", busy); end
    idle(6);
    checks++; if (bytes_str(got_bytes) != "11 22 33 ") begin errors++; $display("FAIL badchk_bytes: got '%s' expected '11 22 33 '", bytes_str(got_bytes)); end
    checks++; if (ev_str(got_ev) != "E1 ") begin errors++; $display("FAIL badchk_events: got '%s' expected 'E1 '", ev_str(got_ev)); end
  endtask

  task automatic test_length_error();
    clear_obs(); payload_ready = 1'b1;
    push_byte(8'hA5); push_byte(8'h11);
    push_byte(8'hA5); push_byte(8'h02); push_byte(8'hAA); push_byte(8'hBB); push_byte(8'h13);
    send_stim(0);
    idle(10);
    checks++; if (ev_str(got_ev) != "E2 D ") begin errors++; $display("FAIL len_events: got '%s' expected 'E2 D '", ev_str(got_ev)); end
    checks++; if (bytes_str(got_bytes) != "aa bb ") begin errors++; $display("FAIL len_bytes: got '%s' expected 'aa bb '", bytes_str(got_bytes)); end
    checks++; if (err_code !== 2'd2) begin errors++; $display("FAIL len_code_held: got %0d expected 2", err_code); end
  endtask

  task automatic test_overflow();
    clear_obs(); payload_ready = 1'b0;
    push_byte(8'hA5); push_byte(8'h06);
    for (int i = 1; i <= 6; i++) push_byte(8'(i));
    push_byte(8'h00);
    send_stim(0);
    idle(10);
    checks++; if (ev_str(got_ev) != "E3 ") begin errors++; $display("FAIL ovf_events: got '%s' expected 'E3 '", ev_str(got_ev)); end
    checks++; if (payload_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid: got %b expected 1", payload_valid); end
    payload_ready = 1'b1;
    idle(10);
    checks++; if (bytes_str(got_bytes) != "01 02 03 04 ") begin errors++; $display("FAIL ovf_bytes: got '%s' expected '01 02 03 04 '", bytes_str(got_bytes)); end
  endtask

  task automatic test_timeout();
    int seen_at = -1;
    clear_obs(); payload_ready = 1'b1;
    push_byte(8'hA5); push_byte(8'h03);
    send_stim(0);
    for (int c = 1; c <= TIMEOUT + 8 && seen_at < 0; c++) begin
      tick();
      if (frame_err) seen_at = c;
    end
    checks++; if (seen_at < TIMEOUT - 2 || seen_at > TIMEOUT + 4) begin errors++; $display("FAIL timeout_when: got cycle %0d expected about %0d", seen_at, TIMEOUT); end
    checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL timeout_code: got %0d expected 0", err_code); end
    idle(4);
    checks++; if (ev_str(got_ev) != "E0 ") begin errors++; $display("FAIL timeout_events: got '%s' expected 'E0 '", ev_str(got_ev)); end
  endtask

  // Each byte completes exactly on the clock where the idle count expires.
  task automatic test_timeout_boundary();
    clear_obs(); payload_ready = 1'b1;
    push_byte(8'hA5); send_stim(0); idle(TIMEOUT - 8);
    push_byte(8'h01); send_stim(0); idle(TIMEOUT - 8);
    push_byte(8'h5A); send_stim(0); idle(TIMEOUT - 8);
    push_byte(8'h5B); send_stim(0);
    idle(6);
    checks++; if (ev_str(got_ev) != "D ") begin errors++; $display("FAIL boundary_events: got '%s' expected 'D '", ev_str(got_ev)); end
    checks++; if (bytes_str(got_bytes) != "5a ") begin errors++; $display("FAIL boundary_bytes: got '%s' expected '5a '", bytes_str(got_bytes)); end
  endtask

  task automatic test_reset_mid();
    clear_obs(); payload_ready = 1'b0;
    push_byte(8'hA5); push_byte(8'h03); push_byte(8'h11);
    send_stim(0);
    idle(2);
    checks++; if (busy !== 1'b1 || payload_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre: got busy=%b valid=%b expected 1 1", busy, payload_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({busy, payload_valid, frame_done, frame_err, err_code, payload_data} !== 14'd0) begin
      errors++; $display("FAIL midrst_outputs: got busy=%b valid=%b done=%b err=%b code=%0d data=%02h expected all 0",
                         busy, payload_valid, frame_done, frame_err, err_code, payload_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    payload_ready = 1'b1;
    idle(10);
    checks++; if (got_ev.size() != 0 || got_bytes.size() != 0) begin errors++; $display("FAIL midrst_quiet: got %0d events %0d bytes expected 0 0", got_ev.size(), got_bytes.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
  endtask

  task automatic test_random();
    int nj, len;
    logic [7:0] sum, b;
    int gi;
    logic [7:0] gb;
    for (int r = 0; r < 3; r++) begin
      clear_obs();
      for (int f = 0; f < 5; f++) begin
        nj  = $urandom_range(0, 12);
        len = $urandom_range(0, 20);
        repeat (nj) stim.push_back(1'($urandom_range(0, 1)));
        push_byte(8'hA5);
        push_byte(8'(len));
        sum = 8'(len);
        for (int k = 0; k < len; k++) begin
          b = 8'($urandom_range(0, 255));
          push_byte(b);
          sum ^= b;
        end
        if ($urandom_range(0, 3) == 0) sum ^= 8'(1 << $urandom_range(0, 7));
        push_byte(sum);
      end
      model_run();
      rnd_ready = 1;
      send_stim(3);
      rnd_ready = 0;
      payload_ready = 1'b1;
      idle(TIMEOUT + 16);
      checks++; if (got_ev.size() != exp_ev.size()) begin errors++; $display("FAIL rand%0d_event_count: got %0d expected %0d", r, got_ev.size(), exp_ev.size()); end
      for (int i = 0; i < exp_ev.size(); i++) begin
        gi = (i < got_ev.size()) ? got_ev[i] : -99;
        checks++;
        if (gi != exp_ev[i]) begin errors++; $display("FAIL rand%0d_event[%0d]: got %0d expected %0d", r, i, gi, exp_ev[i]); break; end
      end
      checks++; if (got_bytes.size() != exp_bytes.size()) begin errors++; $display("FAIL rand%0d_byte_count: got %0d expected %0d", r, got_bytes.size(), exp_bytes.size()); end
      for (int i = 0; i < exp_bytes.size(); i++) begin
        gb = (i < got_bytes.size()) ? got_bytes[i] : 8'hxx;
        checks++;
        if (gb !== exp_bytes[i]) begin errors++; $display("FAIL rand%0d_byte[%0d]: got %02h expected %02h", r, i, gb, exp_bytes[i]); break; end
      end
    end
  endtask

  task automatic test_exclusive();
    checks++; if (both_cnt != 0) begin errors++; $display("FAIL done_err_overlap: got %0d cycles expected 0", both_cnt); end
  endtask

  initial begin
    rst_n = 1'b0; shift_enable = 1'b0; serial_in = 1'b0; payload_ready = 1'b1;
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_length_error();
    test_overflow();
    test_timeout();
    test_timeout_boundary();
    test_reset_mid();
    test_random();
    test_exclusive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
